// File: rtl/jpeg_dequantization_if.sv
// Coefficient stream bundle for the dequantizer.
// Input triples in, dequantized triples out, valid/ready on both sides.
interface jpeg_dequantization_if #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 14
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  Y_in;
    logic signed [IN_W-1:0]  Cb_in;
    logic signed [IN_W-1:0]  Cr_in;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] Y_out;
    logic signed [OUT_W-1:0] Cb_out;
    logic signed [OUT_W-1:0] Cr_out;
    logic [2:0]              out_x;
    logic [2:0]              out_y;
    logic                    out_last;
    logic                    sat;

    modport slave (
        input  in_valid, Y_in, Cb_in, Cr_in, out_ready,
        output in_ready, out_valid, Y_out, Cb_out, Cr_out,
        output out_x, out_y, out_last, sat
    );

    modport master (
        output in_valid, Y_in, Cb_in, Cr_in, out_ready,
        input  in_ready, out_valid, Y_out, Cb_out, Cr_out,
        input  out_x, out_y, out_last, sat
    );
endinterface

// File: rtl/jpeg_dequantization.sv
// JPEG dequantizer: raster-ordered 8x8 Y/Cb/Cr coefficients times
// the standard quantization step, shifted and saturated, 2 stages.
module jpeg_dequantization #(
    parameter int IN_W        = 10,
    parameter int OUT_W       = 14,
    parameter int SCALE_SHIFT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    jpeg_dequantization_if.slave bus
);
    localparam int P_W = IN_W + 8 + SCALE_SHIFT;
    localparam int W   = ((P_W > OUT_W) ? P_W : OUT_W) + 1;

    localparam logic [0:63][6:0] QL = {
        7'd16, 7'd11, 7'd10, 7'd16, 7'd24,  7'd40,  7'd51,  7'd61,
        7'd12, 7'd12, 7'd14, 7'd19, 7'd26,  7'd58,  7'd60,  7'd55,
        7'd14, 7'd13, 7'd16, 7'd24, 7'd40,  7'd57,  7'd69,  7'd56,
        7'd14, 7'd17, 7'd22, 7'd29, 7'd51,  7'd87,  7'd80,  7'd62,
        7'd18, 7'd22, 7'd37, 7'd56, 7'd68,  7'd109, 7'd103, 7'd77,
        7'd24, 7'd35, 7'd55, 7'd64, 7'd81,  7'd104, 7'd113, 7'd92,
        7'd49, 7'd64, 7'd78, 7'd87, 7'd103, 7'd121, 7'd120, 7'd101,
        7'd72, 7'd92, 7'd95, 7'd98, 7'd112, 7'd100, 7'd103, 7'd99
    };

    localparam logic [0:63][6:0] QC = {
        7'd17, 7'd18, 7'd24, 7'd47, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd18, 7'd21, 7'd26, 7'd66, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd24, 7'd26, 7'd56, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd47, 7'd66, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        {32{7'd99}}
    };

    function automatic logic signed [W-1:0] scale(
        input logic signed [IN_W-1:0] c,
        input logic [6:0]             q
    );
        logic signed [P_W-1:0] a, b, p;
        a = {{(P_W-IN_W){c[IN_W-1]}}, c};
        b = {{(P_W-7){1'b0}}, q};
        p = (a * b) <<< SCALE_SHIFT;
        return {{(W-P_W){p[P_W-1]}}, p};
    endfunction

    // Returns {saturated, clipped value}.
    function automatic logic [OUT_W:0] clip(input logic signed [W-1:0] v);
        logic signed [W-1:0] hi, lo;
        hi = W'((1 << (OUT_W-1)) - 1);
        lo = ~hi;
        if (v > hi)      return {1'b1, hi[OUT_W-1:0]};
        else if (v < lo) return {1'b1, lo[OUT_W-1:0]};
        else             return {1'b0, v[OUT_W-1:0]};
    endfunction

    logic [5:0]              pos;
    logic                    s1_valid, s1_last;
    logic [5:0]              s1_pos;
    logic signed [IN_W-1:0]  s1_y, s1_cb, s1_cr;
    logic [6:0]              s1_ql, s1_qc;
    logic                    s2_valid, s2_last, s2_sat;
    logic [2:0]              s2_x, s2_yc;
    logic signed [OUT_W-1:0] s2_y, s2_cb, s2_cr;
    logic [OUT_W:0]          r_y, r_cb, r_cr;
    logic                    s2_en, s1_en, accept;

    assign s2_en        = !s2_valid || bus.out_ready;
    assign s1_en        = !s1_valid || s2_en;
    assign bus.in_ready = !clr && s1_en;
    assign accept       = bus.in_valid && bus.in_ready;

    // Block position advances once per accepted triple.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    pos <= '0;
        else if (clr)    pos <= '0;
        else if (accept) pos <= pos + 6'd1;
    end

    // Stage 1: capture coefficients with their quantization steps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_pos   <= '0;
            s1_y     <= '0;
            s1_cb    <= '0;
            s1_cr    <= '0;
            s1_ql    <= '0;
            s1_qc    <= '0;
        end else if (clr) begin
            s1_valid <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_last <= (pos == 6'd63);
                s1_pos  <= pos;
                s1_y    <= bus.Y_in;
                s1_cb   <= bus.Cb_in;
                s1_cr   <= bus.Cr_in;
                s1_ql   <= QL[pos];
                s1_qc   <= QC[pos];
            end
        end
    end

    // Scale and saturate all three channels.
    always_comb begin
        r_y  = clip(scale(s1_y,  s1_ql));
        r_cb = clip(scale(s1_cb, s1_qc));
        r_cr = clip(scale(s1_cr, s1_qc));
    end

    // Stage 2: output register, held while downstream stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_sat   <= 1'b0;
            s2_x     <= '0;
            s2_yc    <= '0;
            s2_y     <= '0;
            s2_cb    <= '0;
            s2_cr    <= '0;
        end else if (clr) begin
            s2_valid <= 1'b0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_last <= s1_last;
                s2_sat  <= r_y[OUT_W] | r_cb[OUT_W] | r_cr[OUT_W];
                s2_x    <= s1_pos[5:3];
                s2_yc   <= s1_pos[2:0];
                s2_y    <= r_y[OUT_W-1:0];
                s2_cb   <= r_cb[OUT_W-1:0];
                s2_cr   <= r_cr[OUT_W-1:0];
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_last  = s2_valid && s2_last;
    assign bus.sat       = s2_sat;
    assign bus.out_x     = s2_x;
    assign bus.out_y     = s2_yc;
    assign bus.Y_out     = s2_y;
    assign bus.Cb_out    = s2_cb;
    assign bus.Cr_out    = s2_cr;
endmodule

// File: tb/tb_jpeg_dequantization.sv
// Scoreboard bench for jpeg_dequantization: random and directed
// streams checked against a table-driven reference model.
module tb_jpeg_dequantization;
    localparam int IN_W  = 10;
    localparam int OUT_W = 14;
    localparam int HI    = 8191;
    localparam int LO    = -8192;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    jpeg_dequantization_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    jpeg_dequantization #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SCALE_SHIFT(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clr(clr), .bus(bus)
    );

    typedef struct {
        int y, cb, cr, x, yc;
        bit last, sat;
    } exp_t;

    int QL[64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };
    int QC[64];

    exp_t sb[$];
    int   got_y[$];
    int   got_cb[$];
    bit   got_sat[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, mpos = 0;
    int   n_out = 0, n_last = 0, last_idx = 0;
    int   last_x = -1, last_yc = -1;
    int   acc_cyc = -1, first_out_cyc = -1;
    bit   rnd_rdy = 1'b0;
    bit   stalled = 1'b0;
    bit   seen_ready;
    logic [3*OUT_W+7:0] hold;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int clipv(int v);
        return (v > HI) ? HI : (v < LO) ? LO : v;
    endfunction

    function automatic bit oor(int v);
        return (v > HI) || (v < LO);
    endfunction

    function automatic void model(int y, int cb, int cr);
        exp_t e;
        int py, pc, pr;
        py     = y * QL[mpos] * 2;
        pc     = cb * QC[mpos] * 2;
        pr     = cr * QC[mpos] * 2;
        e.y    = clipv(py);
        e.cb   = clipv(pc);
        e.cr   = clipv(pr);
        e.sat  = oor(py) || oor(pc) || oor(pr);
        e.x    = mpos / 8;
        e.yc   = mpos % 8;
        e.last = (mpos == 63);
        sb.push_back(e);
        mpos = (mpos + 1) % 64;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit v, input int y, input int cb,
                        input int cr, input bit c, output bit acc);
        @(negedge clk);
        bus.in_valid  = v;
        bus.Y_in      = IN_W'(y);
        bus.Cb_in     = IN_W'(cb);
        bus.Cr_in     = IN_W'(cr);
        bus.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        clr           = c;
        #4;
        seen_ready = bus.in_ready;
        acc = v && bus.in_ready && reset_n && !c;
        if (acc) begin
            if (acc_cyc < 0) acc_cyc = cyc;
            model(y, cb, cr);
        end
        if (c) mpos = 0;
    endtask

    task automatic send(input int y, input int cb, input int cr);
        bit acc;
        int tries;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 200) begin
            step(1'b1, y, cb, cr, 1'b0, acc);
            tries++;
        end
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        bit acc;
        int t;
        t = 0;
        while ((sb.size() > 0 || bus.out_valid) && t < 500) begin
            step(1'b0, 0, 0, 0, 1'b0, acc);
            t++;
        end
        step(1'b0, 0, 0, 0, 1'b0, acc);
        chk("drain_left", sb.size(), 0);
    endtask

    task automatic restart();
        bit acc;
        step(1'b0, 0, 0, 0, 1'b1, acc);
        step(1'b0, 0, 0, 0, 1'b0, acc);
        got_y.delete();
        got_cb.delete();
        got_sat.delete();
        n_out = 0;
        n_last = 0;
        last_idx = 0;
    endtask

    function automatic int rv();
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    // Monitor: pops the scoreboard on every output handshake.
    always begin
        exp_t e;
        logic [3*OUT_W+7:0] cur;
        @(negedge clk);
        #4;
        cur = {bus.Y_out, bus.Cb_out, bus.Cr_out, bus.out_x,
               bus.out_y, bus.out_last, bus.sat};
        if (!reset_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (!bus.out_valid || cur !== hold) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b %h expected v=1 %h",
                             bus.out_valid, cur, hold);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (first_out_cyc < 0) first_out_cyc = cyc;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got Y=%0d x=%0d y=%0d expected none",
                             bus.Y_out, bus.out_x, bus.out_y);
                end else begin
                    e = sb.pop_front();
                    if (int'(bus.Y_out) != e.y || int'(bus.Cb_out) != e.cb ||
                        int'(bus.Cr_out) != e.cr || int'(bus.out_x) != e.x ||
                        int'(bus.out_y) != e.yc || bus.out_last != e.last ||
                        bus.sat != e.sat) begin
                        errors++;
                        $display("FAIL output: got %0d %0d %0d x%0d y%0d l%0b s%0b expected %0d %0d %0d x%0d y%0d l%0b s%0b",
                                 bus.Y_out, bus.Cb_out, bus.Cr_out, bus.out_x,
                                 bus.out_y, bus.out_last, bus.sat, e.y, e.cb,
                                 e.cr, e.x, e.yc, e.last, e.sat);
                    end
                end
                got_y.push_back(int'(bus.Y_out));
                got_cb.push_back(int'(bus.Cb_out));
                got_sat.push_back(bus.sat);
                n_out++;
                if (bus.out_last) begin
                    n_last++;
                    last_idx = n_out;
                end
                last_x  = int'(bus.out_x);
                last_yc = int'(bus.out_y);
            end
            stalled = bus.out_valid && !bus.out_ready && !clr;
            hold = cur;
            if (clr) sb.delete();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        int row0[8] = '{32, 22, 20, 32, 48, 80, 102, 122};
        for (int i = 0; i < 64; i++) QC[i] = 99;
        for (int i = 0; i < 4; i++) QC[i] = (i == 0) ? 17 : (i == 1) ? 18 : (i == 2) ? 24 : 47;
        for (int i = 0; i < 4; i++) QC[8+i] = (i == 0) ? 18 : (i == 1) ? 21 : (i == 2) ? 26 : 66;
        QC[16] = 24; QC[17] = 26; QC[18] = 56;
        QC[24] = 47; QC[25] = 66;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.Y_in      = '0;
        bus.Cb_in     = '0;
        bus.Cr_in     = '0;

        // reset state
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_Y_out", int'(bus.Y_out), 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_sat", bus.sat, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // block of all ones, latency and last flag
        restart();
        acc_cyc = -1;
        first_out_cyc = -1;
        for (int p = 0; p < 64; p++) send(1, 1, 1);
        drain();
        chk("latency", first_out_cyc - acc_cyc, 2);
        for (int i = 0; i < 8; i++) chk("ones_row0", got_y[i], row0[i]);
        chk("ones_cb0", got_cb[0], 34);
        chk("ones_count", n_out, 64);
        chk("ones_last_count", n_last, 1);
        chk("ones_last_index", last_idx, 64);

        // small negatives
        restart();
        for (int p = 0; p < 64; p++)
            send((p == 0 || p == 63) ? -3 : 0, (p == 9) ? -1 : 0, 0);
        drain();
        chk("neg_y0", got_y[0], -96);
        chk("neg_y63", got_y[63], -594);
        chk("neg_cb9", got_cb[9], -42);

        // saturation boundaries
        restart();
        for (int p = 0; p < 64; p++) send((p == 53) ? 511 : 0, 0, 0);
        for (int p = 0; p < 64; p++)
            send((p == 0) ? 33 : (p == 53) ? -512 : 0, 0, 0);
        drain();
        chk("sat_pos_y", got_y[53], 8191);
        chk("sat_pos_flag", got_sat[53], 1);
        chk("nosat_y", got_y[64], 1056);
        chk("nosat_flag", got_sat[64], 0);
        chk("sat_neg_y", got_y[117], -8192);
        chk("sat_neg_flag", got_sat[117], 1);

        // random stream, random backpressure, 3 blocks
        restart();
        rnd_rdy = 1'b1;
        for (int n = 0; n < 192; n++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 0, 0, 0, 1'b0, acc);
            send(rv(), rv(), rv());
        end
        drain();
        chk("rand_count", n_out, 192);
        chk("rand_lasts", n_last, 3);

        // clear in the middle of a block
        restart();
        for (int n = 0; n < 20; n++) send(rv(), rv(), rv());
        step(1'b1, 100, 100, 100, 1'b1, acc);
        chk("clr_in_ready", seen_ready, 0);
        rnd_rdy = 1'b0;
        send(2, 3, 4);
        drain();
        chk("clr_x", last_x, 0);
        chk("clr_y", last_yc, 0);

        // asynchronous reset mid-stream
        restart();
        for (int n = 0; n < 10; n++) send(5, 5, 5);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        chk("pre_rst_valid", bus.out_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_Y", int'(bus.Y_out), 0);
        chk("mid_rst_Cb", int'(bus.Cb_out), 0);
        sb.delete();
        mpos = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n_out = 0;
        send(7, 1, 1);
        drain();
        chk("post_rst_count", n_out, 1);
        chk("post_rst_x", last_x, 0);
        chk("post_rst_y", last_yc, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
